disp_scan_ctrl: RTL and testbench
=================================

// Module: disp_scan_ctrl
// PURPOSE
//  Time-multiplexed 6-digit 7-segment display scheduler for the BCD clock.
//  - Shares one segment bus between six digits (HH:MM:SS) by round-robin strobing.
//  - Blanks the field selected by the time-setting FSM at a fixed blink rate.
//  - Frame-snapshots the time so a frame never tears mid-scan.
//  - Sits between the counter/setter outputs and the board's seg/digit pins.
// PARAMETERS
//  CLK_HZ    50_000_000  system clock frequency
//  SCAN_HZ   1000        per-digit slot rate; SCAN_DIV = CLK_HZ/SCAN_HZ cycles per slot (>=2)
//  BLINK_HZ  2           blink rate; BLINK_DIV = CLK_HZ/(2*BLINK_HZ) cycles per phase
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  hh           in   8  BCD hours 00-23
//  mm           in   8  BCD minutes 00-59
//  ss           in   8  BCD seconds 00-59
//  blink_sel    in   2  0=HH, 1=MM, 2=SS, 3=no blink
//  seg_n        out  7  active-low segments {g,f,e,d,c,b,a}
//  dig_n        out  6  active-low digit enables; bit0 = SS ones ... bit5 = HH tens
//  blink_phase  out  1  1 = selected field currently blanked
// BEHAVIOUR
//  - One clock, synchronous active-high reset; all outputs registered.
//  - Reset values: seg_n=7'h7F, dig_n=6'h3F, blink_phase=0.
//    Internals cleared: scan_cnt=0, digit=0, blink_cnt=0, snapshot=24'h000000.
//  - Scan:
//    - scan_cnt counts 0..SCAN_DIV-1. On wrap, digit advances 0->1->...->5->0.
//    - Digit map: 0=ss[3:0], 1=ss[7:4], 2=mm[3:0], 3=mm[7:4], 4=hh[3:0], 5=hh[7:4].
//  - Snapshot: {hh,mm,ss} loads when digit==0 && scan_cnt==0, including the first cycle after reset.
//    The decode path uses only the snapshot.
//  - Dead time (anti-ghosting):
//    - When scan_cnt==0, the next-cycle outputs are dig_n=6'h3F, seg_n=7'h7F.
//    - When scan_cnt>=1, the next-cycle outputs are dig_n = ~(1<<digit) and seg_n = decode(nibble).
//    - Latency is 1 clk from internal state to pins.
//  - Decode table (seg_n):
//    - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10.
//    - Nibble >9 shows dash, 7'h3F.
//  - Blink:
//    - When blink_sel==3: blink_cnt=0, blink_phase=0.
//    - Otherwise blink_cnt counts 0..BLINK_DIV-1 and blink_phase toggles on each wrap.
//    - A change of blink_sel (registered compare) clears blink_cnt and blink_phase the next cycle,
//      so a newly selected field is visible immediately.
//    - When blink_phase==1 and digit belongs to the selected field, the slot is forced to
//      dig_n=6'h3F, seg_n=7'h7F. Scan timing is unchanged.
//  - Input changes mid-frame have no effect until the next snapshot.
//  - rst asserted mid-frame returns all state to reset values on the next edge.
// CONFIGURATION
//  LEAD_ZERO_BLANK_EN
//    - Defined: digit 5 is blanked (dig_n=6'h3F, seg_n=7'h7F) when the snapshot hh[7:4]==0.
//    - Not defined: digit 5 always shows its decoded value, including 0.
//    - Blink masking applies on top in both cases.
// TESTING (CLK_HZ=16, SCAN_HZ=4 -> SCAN_DIV=4; BLINK_HZ=1 -> BLINK_DIV=8)
//  1. Reset held 3 clk -> seg_n=7F, dig_n=3F, blink_phase=0. Release with hh/mm/ss=12/34/56, blink_sel=3
//     -> slots cycle digit0..5 at 4 clk each, 1 dead clk per slot. Digit0 shows seg_n=02 ('6').
//     Digit5 shows 79 ('1').
//  2. Change ss 56->57 during digit 2 slot -> digit0 still shows '6' until the next frame, then 78 ('7').
//  3. blink_sel=1 -> MM digits (2,3) alternate visible/blank every 8 clk. Other digits are unaffected.
//     blink_phase toggles every 8 clk.
//  4. Switch blink_sel 1->2 while blink_phase=1 -> next cycle blink_phase=0. SS digits are blanked
//     only after 8 further clk.
//  5. Snapshot hh=8'h0A (invalid) -> digit4 seg_n=3F. hh=8'h09 with LEAD_ZERO_BLANK_EN defined
//     -> digit5 dig_n stays 3F. Not defined -> digit5 shows 40.
//  6. Assert rst mid-slot (scan_cnt=2, digit=3) -> next clk all outputs at reset values.
//     After release, the scan restarts at digit0.

Source files
------------

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: time/blink inputs and segment/digit pins of the display scanner
interface disp_scan_ctrl_if;
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;
   logic [1:0] blink_sel;
   logic [6:0] seg_n;
   logic [5:0] dig_n;
   logic       blink_phase;
   modport master (output hh, mm, ss, blink_sel, input seg_n, dig_n, blink_phase);
   modport slave  (input hh, mm, ss, blink_sel, output seg_n, dig_n, blink_phase);
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 6-digit 7-seg round-robin scanner with field blink and frame snapshot; define LEAD_ZERO_BLANK_EN to blank a zero hours-tens digit
module disp_scan_ctrl #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int SCAN_HZ  = 1000,
   parameter int BLINK_HZ = 2
) (
   input  logic            clk,
   input  logic            rst,
   disp_scan_ctrl_if.slave io_disp
);
   localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
   localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
   logic [SW-1:0] r_scan_cnt;
   logic [2:0]    r_digit;
   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_phase;
   logic [1:0]    r_sel_q;
   logic [23:0]   r_snap;
   logic [6:0]    r_seg_n;
   logic [5:0]    r_dig_n;
   logic [3:0]    w_nib;
   logic [6:0]    w_seg;
   logic          w_lead;
   logic          w_blank;
   logic          w_blink_clr;
   always_comb begin
      w_nib = r_snap[{r_digit, 2'b00} +: 4];
      case (w_nib)
         4'd0:    w_seg = 7'h40;
         4'd1:    w_seg = 7'h79;
         4'd2:    w_seg = 7'h24;
         4'd3:    w_seg = 7'h30;
         4'd4:    w_seg = 7'h19;
         4'd5:    w_seg = 7'h12;
         4'd6:    w_seg = 7'h02;
         4'd7:    w_seg = 7'h78;
         4'd8:    w_seg = 7'h00;
         4'd9:    w_seg = 7'h10;
         default: w_seg = 7'h3F;
      endcase
`ifdef LEAD_ZERO_BLANK_EN
      w_lead = (r_digit == 3'd5) && (r_snap[23:20] == 4'd0);
`else
      w_lead = 1'b0;
`endif
      // digit pairs map to fields as SS=2, MM=1, HH=0 under blink_sel encoding
      w_blank     = (r_scan_cnt == '0) || w_lead ||
                    (r_blink_phase && (r_sel_q == 2'd2 - r_digit[2:1]));
      w_blink_clr = (io_disp.blink_sel == 2'd3) || (io_disp.blink_sel != r_sel_q);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan_cnt    <= '0;
         r_digit       <= 3'd0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_sel_q       <= 2'd3;
         r_snap        <= 24'h000000;
         r_seg_n       <= 7'h7F;
         r_dig_n       <= 6'h3F;
      end else begin
         r_scan_cnt <= (r_scan_cnt == SCAN_MAX) ? '0 : r_scan_cnt + 1'b1;
         if (r_scan_cnt == SCAN_MAX)
            r_digit <= (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
         if (r_digit == 3'd0 && r_scan_cnt == '0)
            r_snap <= {io_disp.hh, io_disp.mm, io_disp.ss};
         r_sel_q <= io_disp.blink_sel;
         if (w_blink_clr) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
         end else if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
         end
         r_dig_n <= w_blank ? 6'h3F : ~(6'd1 << r_digit);
         r_seg_n <= w_blank ? 7'h7F : w_seg;
      end
   end
   assign io_disp.seg_n       = r_seg_n;
   assign io_disp.dig_n       = r_dig_n;
   assign io_disp.blink_phase = r_blink_phase;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scoreboard bench for disp_scan_ctrl at SCAN_DIV=4, BLINK_DIV=8
module tb_disp_scan_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   k = 0;
   int   m_e = -1;
   logic m_phase = 1'b0;
   logic [1:0]  m_selq = 2'd3;
   logic [23:0] m_snap = 24'h0;
   logic [13:0] q[$];
   disp_scan_ctrl_if bus();
   disp_scan_ctrl #(.CLK_HZ(16), .SCAN_HZ(4), .BLINK_HZ(1)) dut (
      .clk(clk), .rst(rst), .io_disp(bus.slave)
   );
   always #5 clk = ~clk;
   function automatic logic [6:0] dec(input logic [3:0] n);
      case (n)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction
   // expected pins after the coming edge, derived from edge index k since reset release
   task automatic cyc();
      logic [6:0] es;
      logic [5:0] ed;
      logic ep, blank;
      int d, s;
      if (rst) begin
         es = 7'h7F; ed = 6'h3F; ep = 1'b0;
         k = 0; m_e = -1; m_phase = 1'b0; m_selq = 2'd3; m_snap = 24'h0;
      end else begin
         d = (k / 4) % 6;
         s = k % 4;
         blank = (s == 0) || (m_phase && (int'(m_selq) == 2 - d / 2));
`ifdef LEAD_ZERO_BLANK_EN
         if (d == 5 && m_snap[23:20] == 4'd0) blank = 1'b1;
`endif
         es = blank ? 7'h7F : dec(m_snap[4*d +: 4]);
         ed = blank ? 6'h3F : ~(6'd1 << d);
         if (d == 0 && s == 0) m_snap = {bus.hh, bus.mm, bus.ss};
         if (bus.blink_sel == 2'd3 || bus.blink_sel != m_selq) m_e = k;
         ep = (((k - m_e) / 8) % 2) == 1;
         m_phase = ep;
         m_selq = bus.blink_sel;
         k++;
      end
      q.push_back({es, ed, ep});
      @(posedge clk);
      #2;
   endtask
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         logic [13:0] exp_v;
         exp_v = q.pop_front();
         n_cmp++;
         if ({bus.seg_n, bus.dig_n, bus.blink_phase} !== exp_v) begin
            n_bad++;
            $display("FAIL sb t=%0t seg/dig/ph got %h/%h/%b want %h/%h/%b", $time,
                     bus.seg_n, bus.dig_n, bus.blink_phase, exp_v[13:7], exp_v[6:1], exp_v[0]);
         end
      end
   end
   task automatic wait_pos(input int d, input int s);
      int n = 0;
      bit hit = 0;
      while (!hit && n < 40) begin
         cyc();
         n++;
         hit = (((k - 1) / 4) % 6 == d) && ((k - 1) % 4 == s);
      end
      if (!hit) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_pos d=%0d s=%0d not reached within 40 clk", d, s);
      end
   endtask
   task automatic test_reset();
      rst = 1'b1; bus.blink_sel = 2'd3;
      bus.hh = 8'h12; bus.mm = 8'h34; bus.ss = 8'h56;
      repeat (3) cyc();
      n_cmp++;
      if ({bus.seg_n, bus.dig_n, bus.blink_phase} !== {7'h7F, 6'h3F, 1'b0}) begin
         n_bad++;
         $display("FAIL reset got %h/%h/%b want 7f/3f/0", bus.seg_n, bus.dig_n, bus.blink_phase);
      end
      rst = 1'b0;
   endtask
   task automatic test_scan();
      wait_pos(0, 1);
      n_cmp++;
      if ({bus.seg_n, bus.dig_n} !== {7'h02, 6'h3E}) begin
         n_bad++; $display("FAIL scan_d0 got %h/%h want 02/3e", bus.seg_n, bus.dig_n);
      end
      wait_pos(5, 1);
      n_cmp++;
      if ({bus.seg_n, bus.dig_n} !== {7'h79, 6'h1F}) begin
         n_bad++; $display("FAIL scan_d5 got %h/%h want 79/1f", bus.seg_n, bus.dig_n);
      end
   endtask
   task automatic test_snapshot();
      wait_pos(2, 1);
      bus.ss = 8'h57;
      wait_pos(0, 2);
      n_cmp++;
      if (bus.seg_n !== 7'h78) begin
         n_bad++; $display("FAIL snap_d0 got %h want 78", bus.seg_n);
      end
   endtask
   task automatic test_blink();
      bus.blink_sel = 2'd1;
      cyc();
      n_cmp++;
      if (bus.blink_phase !== 1'b0) begin
         n_bad++; $display("FAIL blink_start got %b want 0", bus.blink_phase);
      end
      repeat (7) cyc();
      n_cmp++;
      if (bus.blink_phase !== 1'b0) begin
         n_bad++; $display("FAIL blink_7 got %b want 0", bus.blink_phase);
      end
      cyc();
      n_cmp++;
      if (bus.blink_phase !== 1'b1) begin
         n_bad++; $display("FAIL blink_8 got %b want 1", bus.blink_phase);
      end
      repeat (30) cyc();
   endtask
   task automatic test_blink_switch();
      int n = 0;
      while (bus.blink_phase !== 1'b1 && n < 20) begin cyc(); n++; end
      bus.blink_sel = 2'd2;
      cyc();
      n_cmp++;
      if (bus.blink_phase !== 1'b0) begin
         n_bad++; $display("FAIL switch_clr got %b want 0", bus.blink_phase);
      end
      repeat (7) cyc();
      n_cmp++;
      if (bus.blink_phase !== 1'b0) begin
         n_bad++; $display("FAIL switch_7 got %b want 0", bus.blink_phase);
      end
      cyc();
      n_cmp++;
      if (bus.blink_phase !== 1'b1) begin
         n_bad++; $display("FAIL switch_8 got %b want 1", bus.blink_phase);
      end
      repeat (30) cyc();
   endtask
   task automatic test_invalid_lead();
      bus.blink_sel = 2'd3;
      bus.hh = 8'h0A; bus.mm = 8'h00; bus.ss = 8'h00;
      wait_pos(0, 1);
      wait_pos(4, 1);
      n_cmp++;
      if (bus.seg_n !== 7'h3F) begin
         n_bad++; $display("FAIL invalid_d4 got %h want 3f", bus.seg_n);
      end
      bus.hh = 8'h09;
      wait_pos(0, 1);
      wait_pos(5, 1);
      n_cmp++;
`ifdef LEAD_ZERO_BLANK_EN
      if (bus.dig_n !== 6'h3F) begin
         n_bad++; $display("FAIL lead_d5 dig got %h want 3f", bus.dig_n);
      end
`else
      if ({bus.seg_n, bus.dig_n} !== {7'h40, 6'h1F}) begin
         n_bad++; $display("FAIL lead_d5 got %h/%h want 40/1f", bus.seg_n, bus.dig_n);
      end
`endif
   endtask
   task automatic test_mid_reset();
      int n = 0;
      while (k % 24 != 14 && n < 30) begin cyc(); n++; end
      rst = 1'b1;
      cyc();
      n_cmp++;
      if ({bus.seg_n, bus.dig_n, bus.blink_phase} !== {7'h7F, 6'h3F, 1'b0}) begin
         n_bad++;
         $display("FAIL mid_rst got %h/%h/%b want 7f/3f/0", bus.seg_n, bus.dig_n, bus.blink_phase);
      end
      rst = 1'b0;
      cyc();
      cyc();
      n_cmp++;
      if ({bus.seg_n, bus.dig_n} !== {7'h40, 6'h3E}) begin
         n_bad++; $display("FAIL restart_d0 got %h/%h want 40/3e", bus.seg_n, bus.dig_n);
      end
      repeat (30) cyc();
   endtask
   initial begin
      test_reset();
      test_scan();
      test_snapshot();
      test_blink();
      test_blink_switch();
      test_invalid_lead();
      test_mid_reset();
      @(posedge clk);
      #2;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++; $display("FAIL sb_drain left %0d want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
